tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Inverse of the mux-based time-division serializer. It takes one W-bit sample stream in which N_CH channels share the line in fixed slot order.
- Slot 0 is marked by a frame-sync strobe. The block routes each sample to its channel register.
- Completed frames are published as one parallel, double-buffered word with a one-cycle valid pulse.
- Sits at the receive end of the TDM link, feeding per-channel consumers.

Parameters:
- N_CH, 4, number of time-multiplexed channels (>=2).
- W, 8, bits per channel sample.
- SW, $clog2(N_CH), slot index width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  multiplexed sample for the current slot.
- din_valid  input  1  din/fsync are sampled only when high; a low cycle is a stall with no slot advance.
- fsync  input  1  qualified by din_valid; high marks the sample as slot 0.
- dout  output  N_CH*W  published frame; channel k occupies bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse when dout updates.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on framing violation.
- slot  output  SW  index of the next expected slot (0 in HUNT).

Behaviour:
- Reset (async, rst=1):
  - state=HUNT, slot=0.
  - Shadow bank=0, dout=0.
  - frame_valid=0, sync_err=0, locked=0.
  - Outputs hold these values while rst is high. Reset mid-frame discards the partial frame.
- States are HUNT and LOCKED. locked is registered and equals (state==LOCKED).
- HUNT:
  - Samples with din_valid=1 and fsync=0 are discarded.
  - On din_valid=1 and fsync=1: shadow[0]<=din, slot<=1, state<=LOCKED.
- LOCKED, on din_valid=1:
  - Normal case (fsync==(slot==0)): shadow[slot]<=din.
    - If slot==N_CH-1: dout<={din, shadow[N_CH-2:0]}, frame_valid=1 next cycle, slot<=0.
    - Otherwise slot<=slot+1.
  - Early fsync (fsync=1, slot!=0):
    - sync_err pulse; partial frame abandoned, no frame_valid.
    - Sample taken as a new slot 0: shadow[0]<=din, slot<=1, stay LOCKED.
  - Missing fsync (fsync=0, slot==0):
    - sync_err pulse; sample discarded; state<=HUNT, slot<=0.
- LOCKED, din_valid=0: nothing changes; stalls of any length between slots are legal.
- Latency: frame_valid and the new dout are visible the cycle after the clock edge that captures the slot N_CH-1 sample.
- dout is stable between frame_valid pulses; shadow writes never disturb it.
- Back-to-back frames: slot 0 of the next frame may arrive the very cycle after the last slot, giving one frame_valid every N_CH valid cycles.
- frame_valid and sync_err are never high in the same cycle.
- Both pulses are registered and last exactly one cycle.
- Unused shadow contents after an error are don't-care; only fully completed frames reach dout.
- slot wraps N_CH-1 -> 0 explicitly. No reliance on power-of-two N_CH; slot never exceeds N_CH-1.

Test Plan:
1. Clean frame:
   - Stimulus: rst pulse, then din=11,22,33,44 with fsync on the first, din_valid continuous.
   - Required: locked=1 after the first edge; frame_valid one cycle after 44; dout=0x44332211; slot back to 0.
2. Stalls:
   - Stimulus: same frame with din_valid low for 3 cycles between every sample.
   - Required: identical dout=0x44332211; exactly one frame_valid pulse; slot holds during stalls.
3. HUNT discard:
   - Stimulus: din=AA,BB without fsync, then a clean frame 01,02,03,04.
   - Required: AA/BB ignored, locked=0 until 01; dout=0x04030201; no sync_err.
4. Early fsync:
   - Stimulus: 11,22 (fsync on 11), then fsync with 55, then 66,77,88.
   - Required: sync_err pulse on 55; no frame_valid for the aborted frame; dout=0x88776655.
5. Missing fsync:
   - Stimulus: a full frame, then next slot-0 sample 99 with fsync=0.
   - Required: sync_err pulse, locked drops to 0, dout keeps the prior frame; relock only on the next fsync.
6. Async reset mid-frame:
   - Stimulus: assert rst between slot 1 and slot 2 (not on a clock edge).
   - Required: dout=0, locked=0, slot=0 immediately; no frame_valid until a fresh full frame is received.

Source files
------------

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//   Receive-side TDM demultiplexer. One W-bit sample line carries N_CH
//   channels in fixed slot order. Slot 0 is marked by a frame-sync strobe.
//   Samples are collected into a shadow bank. A completed frame is published
//   to dout in a single update, together with a one-cycle frame_valid pulse.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   din          sample for the current slot
//   din_valid    din/fsync qualifier; a low cycle is a stall
//   fsync        marks the current sample as slot 0 (when din_valid=1)
//   dout         published frame, channel k at [k*W +: W]
//   frame_valid  one-cycle pulse when dout updates
//   locked       high while the receiver is aligned to the frame
//   sync_err     one-cycle pulse on a framing violation
//   slot         index of the next expected slot (0 while hunting)
// ---------------------------------------------------------------------------
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         din,
    input  logic                 din_valid,
    input  logic                 fsync,
    output logic [N_CH*W-1:0]    dout,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 sync_err,
    output logic [$clog2(N_CH)-1:0] slot
);

    localparam int SW = $clog2(N_CH);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SW-1:0]           slot_nxt;
    logic                    shadow_we;
    logic [SW-1:0]           wr_idx;
    logic                    publish;
    logic                    err_nxt;

    // Slots 0..N_CH-2 are staged here. The final slot goes straight into
    // dout together with the staged ones, so it never needs a shadow entry.
    logic [N_CH-2:0][W-1:0]  shadow;

    // Every accepted fsync sample lands in entry 0. Otherwise the sample
    // goes to the slot the frame is currently expecting.
    assign wr_idx = fsync ? '0 : slot;

    // Next-state and datapath decisions. Nothing moves on a stall cycle.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        shadow_we = 1'b0;
        publish   = 1'b0;
        err_nxt   = 1'b0;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (fsync) begin
                        shadow_we = 1'b1;
                        slot_nxt  = SW'(1);
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (fsync && (slot != '0)) begin
                        // Early sync: abandon the partial frame and restart on this sample.
                        err_nxt   = 1'b1;
                        shadow_we = 1'b1;
                        slot_nxt  = SW'(1);
                    end else if (!fsync && (slot == '0)) begin
                        // Sync missing where slot 0 was due: alignment lost.
                        err_nxt   = 1'b1;
                        slot_nxt  = '0;
                        state_nxt = HUNT;
                    end else if (slot == SW'(N_CH - 1)) begin
                        // Explicit wrap, so non-power-of-two N_CH works.
                        publish   = 1'b1;
                        slot_nxt  = '0;
                    end else begin
                        shadow_we = 1'b1;
                        slot_nxt  = slot + SW'(1);
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = '0;
                end
            endcase
        end
    end

    // State, slot counter and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= '0;
            locked      <= 1'b0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            locked      <= (state_nxt == LOCKED);
            frame_valid <= publish;
            sync_err    <= err_nxt;
        end
    end

    // The shadow bank and the published frame. dout only changes when a
    // full frame completes, so shadow writes never disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            dout   <= '0;
        end else begin
            for (int k = 0; k < N_CH - 1; k++) begin
                if (shadow_we && (wr_idx == SW'(k))) begin
                    shadow[k] <= din;
                end
            end
            if (publish) begin
                dout <= {din, shadow};
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux
//   Directed bench for tdm_demux. A queue-based frame model tracks the
//   expected outputs. A negedge compare process checks the DUT against the
//   model on every cycle. Directed literal checks pin both the DUT and the
//   model at key points.
// ---------------------------------------------------------------------------
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int SW   = $clog2(N_CH);

    logic                 clk;
    logic                 rst;
    logic [W-1:0]         din;
    logic                 din_valid;
    logic                 fsync;
    logic [N_CH*W-1:0]    dout;
    logic                 frame_valid;
    logic                 locked;
    logic                 sync_err;
    logic [SW-1:0]        slot;

    int checks;
    int errors;
    int fv_count;
    int err_count;
    bit check_en;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .fsync       (fsync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .slot        (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame model: the queue holds the samples of the frame in progress.
    logic [W-1:0]       q[$];
    logic               m_locked;
    logic [N_CH*W-1:0]  m_dout;
    logic               m_fv;
    logic               m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_locked = 1'b0;
            m_dout   = '0;
            m_fv     = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_fv  = 1'b0;
            m_err = 1'b0;
            if (din_valid) begin
                if (!m_locked) begin
                    if (fsync) begin
                        q.delete();
                        q.push_back(din);
                        m_locked = 1'b1;
                    end
                end else if (fsync) begin
                    if (q.size() != 0) m_err = 1'b1;
                    q.delete();
                    q.push_back(din);
                end else if (q.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    q.push_back(din);
                    if (q.size() == N_CH) begin
                        for (int k = 0; k < N_CH; k++) m_dout[k*W +: W] = q[k];
                        m_fv = 1'b1;
                        q.delete();
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [N_CH*W-1:0] actual,
                               input logic [N_CH*W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_dout", dout, m_dout);
            checkOutput("cyc_frame_valid", {31'b0, frame_valid}, {31'b0, m_fv});
            checkOutput("cyc_sync_err", {31'b0, sync_err}, {31'b0, m_err});
            checkOutput("cyc_locked", {31'b0, locked}, {31'b0, m_locked});
            checkOutput("cyc_slot", {30'b0, slot}, 32'(q.size()));
        end
        if (frame_valid === 1'b1) fv_count++;
        if (sync_err === 1'b1) err_count++;
    end

    // Present one valid sample; it is captured on the following rising edge.
    task automatic applyStimulus(input logic [W-1:0] d, input logic fs);
        @(posedge clk);
        #2;
        din       = d;
        fsync     = fs;
        din_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            din_valid = 1'b0;
            fsync     = 1'b0;
        end
    endtask

    // Assert reset away from any clock edge and check the cleared outputs.
    task automatic doReset();
        @(posedge clk);
        #2;
        din_valid = 1'b0;
        fsync     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_dout", dout, '0);
        checkOutput("rst_locked", {31'b0, locked}, 32'd0);
        checkOutput("rst_slot", {30'b0, slot}, 32'd0);
        checkOutput("rst_frame_valid", {31'b0, frame_valid}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        fv_count  = 0;
        err_count = 0;
        check_en  = 1'b0;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        fsync     = 1'b0;
        #12;
        checkOutput("init_dout", dout, '0);
        checkOutput("init_locked", {31'b0, locked}, 32'd0);
        rst      = 1'b0;
        check_en = 1'b1;

        // 1. Clean frame.
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b0);
        checkOutput("t1_locked_after_first", {31'b0, locked}, 32'd1);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        idle(1);
        checkOutput("t1_frame_valid", {31'b0, frame_valid}, 32'd1);
        checkOutput("t1_dout", dout, 32'h44332211);
        checkOutput("t1_model_dout", m_dout, 32'h44332211);
        checkOutput("t1_slot", {30'b0, slot}, 32'd0);

        // 2. Stalls between every sample.
        idle(2);
        fv_count = 0;
        applyStimulus(8'h11, 1'b1); idle(3);
        applyStimulus(8'h22, 1'b0); idle(3);
        applyStimulus(8'h33, 1'b0); idle(3);
        checkOutput("t2_slot_stall", {30'b0, slot}, 32'd3);
        applyStimulus(8'h44, 1'b0); idle(3);
        checkOutput("t2_dout", dout, 32'h44332211);
        checkOutput("t2_fv_count", 32'(fv_count), 32'd1);

        // 3. HUNT discards unsynced samples.
        doReset();
        err_count = 0;
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        idle(1);
        checkOutput("t3_locked_hunt", {31'b0, locked}, 32'd0);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h04, 1'b0);
        idle(2);
        checkOutput("t3_dout", dout, 32'h04030201);
        checkOutput("t3_model_dout", m_dout, 32'h04030201);
        checkOutput("t3_err_count", 32'(err_count), 32'd0);

        // 4. Early fsync restarts the frame.
        fv_count  = 0;
        err_count = 0;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h66, 1'b0);
        checkOutput("t4_sync_err", {31'b0, sync_err}, 32'd1);
        applyStimulus(8'h77, 1'b0);
        applyStimulus(8'h88, 1'b0);
        idle(2);
        checkOutput("t4_dout", dout, 32'h88776655);
        checkOutput("t4_err_count", 32'(err_count), 32'd1);
        checkOutput("t4_fv_count", 32'(fv_count), 32'd1);

        // 5. Missing fsync drops lock.
        applyStimulus(8'hA1, 1'b1);
        applyStimulus(8'hB2, 1'b0);
        applyStimulus(8'hC3, 1'b0);
        applyStimulus(8'hD4, 1'b0);
        applyStimulus(8'h99, 1'b0);
        idle(1);
        checkOutput("t5_sync_err", {31'b0, sync_err}, 32'd1);
        checkOutput("t5_locked", {31'b0, locked}, 32'd0);
        checkOutput("t5_dout_kept", dout, 32'hD4C3B2A1);
        applyStimulus(8'h12, 1'b0);
        idle(1);
        checkOutput("t5_still_hunt", {31'b0, locked}, 32'd0);
        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h30, 1'b0);
        applyStimulus(8'h40, 1'b0);
        idle(2);
        checkOutput("t5_relock_dout", dout, 32'h40302010);

        // 6. Async reset mid-frame.
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b0);
        doReset();
        fv_count = 0;
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h04, 1'b0);
        idle(2);
        checkOutput("t6_no_fv", 32'(fv_count), 32'd0);
        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h06, 1'b0);
        applyStimulus(8'h07, 1'b0);
        applyStimulus(8'h08, 1'b0);
        idle(2);
        checkOutput("t6_dout", dout, 32'h08070605);
        checkOutput("t6_fv_count", 32'(fv_count), 32'd1);

        idle(2);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
